// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares port A of the 16K x 32 VRAM among PPU fetch, DMA and CPU.
//   Reads and full-word writes execute in the grant cycle (gnt is a
//   same-cycle pulse). Partial byte-enabled writes run as read-modify-write:
//   the first cycle reads and merges, the second cycle (RMW_WR) writes and grants.
//   Read data is registered into the requester's rdata at the end of the
//   grant cycle, with rvalid high for exactly the following cycle.
//
// Optional feature: define VRAM_ARB_STARVE_EN to add the anti-starvation
//   counter. After STARVE_MAX consecutive PPU wins over a pending DMA/CPU
//   request, the DMA/CPU request is forced ahead of the PPU.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   ppu_req/addr -> ppu_gnt        PPU read request / same-cycle grant
//   ppu_rvalid/rdata               registered PPU read data
//   dma_*/cpu_*                    req, we, be, addr, wdata in; gnt, rvalid, rdata out
//   vram_addr/we/wdata             to VRAM port A
//   vram_rdata                     from VRAM port A (combinational read)
module vram_arbiter #(
   parameter int AW         = 14,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ppu_req,
   input  logic [AW-1:0]   ppu_addr,
   output logic            ppu_gnt,
   output logic            ppu_rvalid,
   output logic [DW-1:0]   ppu_rdata,
   input  logic            dma_req,
   input  logic            dma_we,
   input  logic [DW/8-1:0] dma_be,
   input  logic [AW-1:0]   dma_addr,
   input  logic [DW-1:0]   dma_wdata,
   output logic            dma_gnt,
   output logic            dma_rvalid,
   output logic [DW-1:0]   dma_rdata,
   input  logic            cpu_req,
   input  logic            cpu_we,
   input  logic [DW/8-1:0] cpu_be,
   input  logic [AW-1:0]   cpu_addr,
   input  logic [DW-1:0]   cpu_wdata,
   output logic            cpu_gnt,
   output logic            cpu_rvalid,
   output logic [DW-1:0]   cpu_rdata,
   output logic [AW-1:0]   vram_addr,
   output logic            vram_we,
   output logic [DW-1:0]   vram_wdata,
   input  logic [DW-1:0]   vram_rdata
);

   localparam int BW = DW / 8;

   typedef enum logic {IDLE, RMW_WR} state_t;

   state_t          state_q, state_d;
   logic            rr_q, rr_d;              // 0: DMA wins a DMA/CPU tie, 1: CPU wins
   logic [AW-1:0]   rmw_addr_q, rmw_addr_d;
   logic [DW-1:0]   rmw_data_q, rmw_data_d;
   logic            rmw_cpu_q, rmw_cpu_d;    // owner of the pending RMW write
   logic            ppu_rvalid_q, dma_rvalid_q, cpu_rvalid_q;
   logic            ppu_rvalid_d, dma_rvalid_d, cpu_rvalid_d;
   logic [DW-1:0]   ppu_rdata_q, dma_rdata_q, cpu_rdata_q;
   logic [DW-1:0]   ppu_rdata_d, dma_rdata_d, cpu_rdata_d;

   logic            dc_pend, pick_dma, force_dc, sel_ppu, sel_dc;
   logic            w_we;
   logic [BW-1:0]   w_be;
   logic [AW-1:0]   w_addr;
   logic [DW-1:0]   w_wdata, merged;

   assign dc_pend  = dma_req | cpu_req;
   assign pick_dma = dma_req & (~cpu_req | ~rr_q);
   assign sel_ppu  = ppu_req & ~force_dc;
   assign sel_dc   = ~sel_ppu & dc_pend;

   assign w_we    = pick_dma ? dma_we    : cpu_we;
   assign w_be    = pick_dma ? dma_be    : cpu_be;
   assign w_addr  = pick_dma ? dma_addr  : cpu_addr;
   assign w_wdata = pick_dma ? dma_wdata : cpu_wdata;

   // RMW merge: enabled bytes from the requester, the rest from the current word
   generate
      for (genvar gi = 0; gi < BW; gi++) begin : g_merge
         assign merged[gi*8 +: 8] = w_be[gi] ? w_wdata[gi*8 +: 8] : vram_rdata[gi*8 +: 8];
      end
   endgenerate

`ifdef VRAM_ARB_STARVE_EN
   localparam int CW = $clog2(STARVE_MAX + 1);
   logic [CW-1:0] starve_q, starve_d;

   assign force_dc = (starve_q >= CW'(STARVE_MAX)) & dc_pend;

   always_comb begin
      starve_d = starve_q;
      if (dma_gnt | cpu_gnt)
         starve_d = '0;
      else if (rst_n && state_q == IDLE && sel_ppu && dc_pend && starve_q < CW'(STARVE_MAX))
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) starve_q <= '0;
      else        starve_q <= starve_d;
   end
`else
   logic unused_starve_max;
   assign unused_starve_max = (STARVE_MAX != 0);
   assign force_dc          = 1'b0;
`endif

   // Everything driven toward the RAM and every grant is gated by rst_n so
   // that asserting reset silences the port immediately, even mid-RMW.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      rmw_addr_d = rmw_addr_q;
      rmw_data_d = rmw_data_q;
      rmw_cpu_d  = rmw_cpu_q;
      vram_addr  = '0;
      vram_we    = 1'b0;
      vram_wdata = '0;
      ppu_gnt    = 1'b0;
      dma_gnt    = 1'b0;
      cpu_gnt    = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            IDLE: begin
               if (sel_ppu) begin
                  vram_addr = ppu_addr;
                  ppu_gnt   = 1'b1;
               end else if (sel_dc) begin
                  vram_addr = w_addr;
                  if (w_we && w_be != '0 && w_be != '1) begin
                     rmw_addr_d = w_addr;
                     rmw_data_d = merged;
                     rmw_cpu_d  = ~pick_dma;
                     state_d    = RMW_WR;
                  end else begin
                     vram_we    = w_we & (w_be == '1);
                     vram_wdata = vram_we ? w_wdata : '0;
                     dma_gnt    = pick_dma;
                     cpu_gnt    = ~pick_dma;
                     rr_d       = pick_dma;
                  end
               end
            end
            RMW_WR: begin
               vram_addr  = rmw_addr_q;
               vram_we    = 1'b1;
               vram_wdata = rmw_data_q;
               dma_gnt    = ~rmw_cpu_q;
               cpu_gnt    = rmw_cpu_q;
               rr_d       = ~rmw_cpu_q;
               state_d    = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Read data capture; DMA/CPU grants in IDLE with we=0 are the only reads
   always_comb begin
      ppu_rvalid_d = ppu_gnt;
      dma_rvalid_d = dma_gnt & (state_q == IDLE) & ~dma_we;
      cpu_rvalid_d = cpu_gnt & (state_q == IDLE) & ~cpu_we;
      ppu_rdata_d  = ppu_rvalid_d ? vram_rdata : ppu_rdata_q;
      dma_rdata_d  = dma_rvalid_d ? vram_rdata : dma_rdata_q;
      cpu_rdata_d  = cpu_rvalid_d ? vram_rdata : cpu_rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_q         <= 1'b0;
         rmw_addr_q   <= '0;
         rmw_data_q   <= '0;
         rmw_cpu_q    <= 1'b0;
         ppu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         ppu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         cpu_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         rmw_addr_q   <= rmw_addr_d;
         rmw_data_q   <= rmw_data_d;
         rmw_cpu_q    <= rmw_cpu_d;
         ppu_rvalid_q <= ppu_rvalid_d;
         dma_rvalid_q <= dma_rvalid_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         ppu_rdata_q  <= ppu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
      end
   end

   assign ppu_rvalid = ppu_rvalid_q;
   assign dma_rvalid = dma_rvalid_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign ppu_rdata  = ppu_rdata_q;
   assign dma_rdata  = dma_rdata_q;
   assign cpu_rdata  = cpu_rdata_q;

endmodule
